// File: rtl/video_pkg.sv
// Shared types and helpers for the video test-pattern source.
// Pattern mode encoding and the colour-bar lookup used by the top level.
package video_pkg;

    typedef enum logic [1:0] {
        VP_SOLID = 2'd0,
        VP_BARS  = 2'd1,
        VP_GRAD  = 2'd2,
        VP_CHECK = 2'd3
    } vp_mode_t;

    localparam int MAX_BPC = 16;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
    // R = ~idx[1], G = ~idx[2], B = ~idx[0]; result is {R,G,B} packed at bpc spacing.
    function automatic logic [3*MAX_BPC-1:0] bar_rgb(input logic [2:0] idx, input int bpc);
        logic [3*MAX_BPC-1:0] full;
        logic [3*MAX_BPC-1:0] res;
        full = ~({(3*MAX_BPC){1'b1}} << bpc);
        res  = '0;
        if (!idx[1]) res = res | (full << (2 * bpc));
        if (!idx[2]) res = res | (full << bpc);
        if (!idx[0]) res = res | full;
        return res;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Pixel/line counters for the pattern source, with region flags decoded
// from the current counter position (combinational, registered by the top).
module video_timing_counter #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int CW       = 11
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          active,
    output logic          hsync,
    output logic          vsync,
    output logic          line_last,
    output logic          frame_start,
    output logic          frame_end
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOT > 2**CW || V_TOT > 2**CW) begin : g_cw_check
        $error("video_timing_counter: H or V total does not fit in CW bits");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (col == H_LAST) begin
            col <= '0;
            row <= (row == V_LAST) ? '0 : row + 1'b1;
        end else begin
            col <= col + 1'b1;
        end
    end

    always_comb begin
        active      = (col < H_ACT) && (row < V_ACT);
        hsync       = (col >= HS_FIRST) && (col <= HS_LAST);
        vsync       = (row >= VS_FIRST) && (row <= VS_LAST);
        line_last   = (col == H_ACT_LAST) && (row < V_ACT);
        frame_start = (col == '0) && (row == '0);
        frame_end   = (col == H_LAST) && (row == V_LAST);
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern source in the pixel-clock domain.
// Mode/colour are captured at the top-left pixel and held for the whole frame.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter int HSYNC_POL  = 1,
    parameter int VSYNC_POL  = 1,
    parameter int BPC        = 4,
    parameter int CW         = 11,
    parameter int GRAD_SHIFT = 5,
    parameter int CHK_LOG2   = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       mode_i,
    input  logic [3*BPC-1:0] color_i,
    output logic             de_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic [3*BPC-1:0] pix_o,
    output logic             sof_o,
    output logic             eol_o,
    output logic [7:0]       frame_o
);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [CW-1:0]    col;
    logic [CW-1:0]    row;
    logic             active;
    logic             hsync;
    logic             vsync;
    logic             line_last;
    logic             frame_start;
    logic             frame_end;

    vp_mode_t         mode_q;
    vp_mode_t         mode_eff;
    logic [3*BPC-1:0] color_q;
    logic [3*BPC-1:0] color_eff;
    logic [7:0]       frame_cnt;
    logic [2:0]       bar_idx;
    logic [BPC-1:0]   grad;
    logic [CW-1:0]    chk_sum;
    logic             chk_on;
    logic [3*BPC-1:0] pix_next;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_timing (
        .clk         (clk_i),
        .rst         (rst_i),
        .col         (col),
        .row         (row),
        .active      (active),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_last   (line_last),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    // The (0,0) pixel already uses the freshly sampled inputs, so bypass the latch there.
    assign mode_eff  = frame_start ? vp_mode_t'(mode_i) : mode_q;
    assign color_eff = frame_start ? color_i : color_q;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (col >= CW'((k * H_ACTIVE) / 8)) bar_idx = 3'(k);
        end
    end

    assign grad    = col[GRAD_SHIFT +: BPC];
    assign chk_sum = col + CW'(frame_cnt);
    assign chk_on  = chk_sum[CHK_LOG2] ^ row[CHK_LOG2];

    always_comb begin
        pix_next = '0;
        case (mode_eff)
            VP_SOLID: pix_next = color_eff;
            VP_BARS:  pix_next = (3*BPC)'(bar_rgb(bar_idx, BPC));
            VP_GRAD:  pix_next = {grad, grad, grad};
            VP_CHECK: pix_next = chk_on ? '1 : '0;
            default:  pix_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            de_o      <= 1'b0;
            hsync_o   <= ~HS_ON;
            vsync_o   <= ~VS_ON;
            pix_o     <= '0;
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            frame_o   <= 8'd0;
            frame_cnt <= 8'd0;
            mode_q    <= VP_SOLID;
            color_q   <= '0;
        end else begin
            de_o      <= active;
            hsync_o   <= hsync ? HS_ON : ~HS_ON;
            vsync_o   <= vsync ? VS_ON : ~VS_ON;
            pix_o     <= active ? pix_next : '0;
            sof_o     <= frame_start;
            eol_o     <= line_last;
            frame_o   <= frame_cnt;
            mode_q    <= mode_eff;
            color_q   <= color_eff;
            // Advances together with the counter wrap so the new frame's pixels see the new count.
            if (frame_end) frame_cnt <= frame_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a shrunken raster.
// A behavioural model pushes expected outputs per cycle; they are popped and checked after the edge.
module tb_video_pattern_gen;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HP  = 0;
    localparam int VP  = 1;
    localparam int BPC = 4;
    localparam int CW  = 6;
    localparam int GS  = 1;
    localparam int CL  = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd1;
    logic [11:0] color = 12'h000;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [11:0] pix;
    logic        sof;
    logic        eol;
    logic [7:0]  frame;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] pix;
        logic        sof;
        logic        eol;
        logic [7:0]  frame;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mc = 0;
    int          mr = 0;
    int          mf = 0;
    logic [1:0]  mmode = 2'd0;
    logic [11:0] mcolor = 12'h000;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    video_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .HSYNC_POL (HP), .VSYNC_POL (VP), .BPC (BPC), .CW (CW),
        .GRAD_SHIFT (GS), .CHK_LOG2 (CL)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .mode_i  (mode),
        .color_i (color),
        .de_o    (de),
        .hsync_o (hsync),
        .vsync_o (vsync),
        .pix_o   (pix),
        .sof_o   (sof),
        .eol_o   (eol),
        .frame_o (frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (model col=%0d row=%0d frame=%0d)",
                   tag, obs, exp, mc, mr, mf);
        end
    endtask

    task automatic model_out(output exp_t e);
        int g;
        int s;
        if (mc == 0 && mr == 0) begin
            mmode  = mode;
            mcolor = color;
        end
        e.de  = (mc < HA) && (mr < VA);
        e.hs  = (mc >= HA + HFP && mc < HA + HFP + HS) ? (HP != 0) : (HP == 0);
        e.vs  = (mr >= VA + VFP && mr < VA + VFP + VS) ? (VP != 0) : (VP == 0);
        e.pix = 12'h000;
        if (e.de) begin
            case (mmode)
                2'd0: e.pix = mcolor;
                2'd1: e.pix = bars[(mc * 8) / HA];
                2'd2: begin
                    g = (mc >> GS) % 16;
                    e.pix = {g[3:0], g[3:0], g[3:0]};
                end
                default: begin
                    s = (mc + mf) % (1 << CW);
                    e.pix = ((((s >> CL) ^ (mr >> CL)) & 1) != 0) ? 12'hFFF : 12'h000;
                end
            endcase
        end
        e.sof   = (mc == 0) && (mr == 0);
        e.eol   = (mc == HA - 1) && (mr < VA);
        e.frame = 8'(mf % 256);
    endtask

    task automatic cycle();
        exp_t e;
        model_out(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("de",    32'(de),    32'(e.de));
        check("hsync", 32'(hsync), 32'(e.hs));
        check("vsync", 32'(vsync), 32'(e.vs));
        check("pix",   32'(pix),   32'(e.pix));
        check("sof",   32'(sof),   32'(e.sof));
        check("eol",   32'(eol),   32'(e.eol));
        check("frame", 32'(frame), 32'(e.frame));
        mc++;
        if (mc == HT) begin
            mc = 0;
            mr++;
            if (mr == VT) begin
                mr = 0;
                mf++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int c, input int r);
        int budget;
        budget = HT * VT + 2;
        while (!(mc == c && mr == r) && budget > 0) begin
            cycle();
            budget--;
        end
        check("run_to_budget", 32'(budget > 0), 32'd1);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_de"},    32'(de),    32'd0);
        check({pfx, "_hsync"}, 32'(hsync), (HP == 0) ? 32'd1 : 32'd0);
        check({pfx, "_vsync"}, 32'(vsync), (VP == 0) ? 32'd1 : 32'd0);
        check({pfx, "_pix"},   32'(pix),   32'd0);
        check({pfx, "_sof"},   32'(sof),   32'd0);
        check({pfx, "_eol"},   32'(eol),   32'd0);
        check({pfx, "_frame"}, 32'(frame), 32'd0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check_reset("reset");

        // Bars in frame 0; checkerboard requested mid-frame applies from frame 1.
        rst = 1'b0;
        mc = 0; mr = 0; mf = 0;
        run(HT * 3);
        mode = 2'd3;
        run_to(0, 0);

        // Checkerboard frame 1; solid colour requested mid-frame for frame 2.
        run(HT * 2 + 5);
        mode  = 2'd0;
        color = 12'h5A3;
        run_to(0, 0);

        // Gradient requested at row 3 must not disturb the solid frame.
        run(HT * 3);
        mode = 2'd2;
        run_to(0, 0);

        // Gradient frame 3, then checkerboard with frame offset 4.
        run(HT * VT);
        mode = 2'd3;
        run_to(5, 3);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check_reset("async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset("held");

        // Restart from (0,0) with frame count cleared.
        rst = 1'b0;
        mc = 0; mr = 0; mf = 0;
        run(HT * VT + HT * 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
